// File: rtl/mac_tree_acc_pkg.sv
// Shared types and helpers for the mac_tree_acc dot-product engine.
package mac_pkg;

  localparam int unsigned MAX_W = 64;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } mac_sb_t;

  typedef struct packed {
    logic             sat;
    logic [MAX_W-1:0] value;
  } sat_res_t;

  function automatic int unsigned tree_depth(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Number of nodes left after `level` rounds of pairwise reduction.
  function automatic int unsigned level_count(input int unsigned n_leaves, input int unsigned level);
    return (n_leaves + (32'd1 << level) - 32'd1) >> level;
  endfunction

  // Round-half-up arithmetic shift followed by signed clamp to `width` bits.
  function automatic sat_res_t sat_scale(input logic signed [MAX_W-1:0] value,
                                         input int unsigned scale,
                                         input int unsigned width);
    logic signed [MAX_W:0] one;
    logic signed [MAX_W:0] x;
    logic signed [MAX_W:0] hi;
    logic signed [MAX_W:0] lo;
    sat_res_t              r;
    one = 1;
    x   = {value[MAX_W-1], value};
    if (scale != 0) x = (x + (one <<< (scale - 1))) >>> scale;
    hi      = (one <<< (width - 1)) - one;
    lo      = -(one <<< (width - 1));
    r.sat   = 1'b0;
    r.value = x[MAX_W-1:0];
    if (x > hi) begin
      r.sat   = 1'b1;
      r.value = hi[MAX_W-1:0];
    end else if (x < lo) begin
      r.sat   = 1'b1;
      r.value = lo[MAX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_tree_acc_if.sv
// Beat input and result output bundle for mac_tree_acc.
interface mac_tree_acc_if #(
  parameter int unsigned N_TAPS            = 9,
  parameter int unsigned A_WIDTH           = 16,
  parameter int unsigned B_WIDTH           = 16,
  parameter int unsigned ACCUMULATOR_WIDTH = 32,
  parameter int unsigned OUTPUT_WIDTH      = 16
);
  logic                           input_valid;
  logic                           input_ready;
  logic [N_TAPS*A_WIDTH-1:0]      a_in;
  logic [N_TAPS*B_WIDTH-1:0]      b_in;
  logic [ACCUMULATOR_WIDTH-1:0]   partial_sum_in;
  logic                           first_in;
  logic                           last_in;
  logic [OUTPUT_WIDTH-1:0]        out;
  logic                           out_valid;
  logic                           out_ready;
  logic                           sat_out;

  modport slave (
    input  input_valid, a_in, b_in, partial_sum_in, first_in, last_in, out_ready,
    output input_ready, out, out_valid, sat_out
  );

  modport master (
    output input_valid, a_in, b_in, partial_sum_in, first_in, last_in, out_ready,
    input  input_ready, out, out_valid, sat_out
  );
endinterface

// File: rtl/mac_tree_acc_adder_tree.sv
// Registered log-depth pairwise adder tree; sideband travels alongside the sum.
module mac_adder_tree
  import mac_pkg::*;
#(
  parameter int unsigned N_LEAVES = 10,
  parameter int unsigned WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      srst,
  input  logic                      en,
  input  logic [N_LEAVES*WIDTH-1:0] leaves,
  input  mac_sb_t                   sb_in,
  output logic [WIDTH-1:0]          sum,
  output mac_sb_t                   sb_out
);
  localparam int unsigned DEPTH = tree_depth(N_LEAVES - 1);

  mac_sb_t sb [DEPTH];

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int unsigned d = 0; d < DEPTH; d++) sb[d] <= '0;
    end else if (en) begin
      sb[0] <= sb_in;
      for (int unsigned d = 1; d < DEPTH; d++) sb[d] <= sb[d-1];
    end
  end

  genvar l, j;
  generate
    for (l = 0; l < DEPTH; l++) begin : g_lvl
      localparam int unsigned N_SRC = level_count(N_LEAVES, l);
      localparam int unsigned N_DST = level_count(N_LEAVES, l + 1);
      logic [N_SRC*WIDTH-1:0] src;
      logic [N_DST*WIDTH-1:0] nxt;
      logic [N_DST*WIDTH-1:0] dst;

      if (l == 0) begin : g_src_leaf
        assign src = leaves;
      end else begin : g_src_prev
        assign src = g_lvl[l-1].dst;
      end

      // An unpaired trailing node is simply re-registered into the next level.
      for (j = 0; j < N_DST; j++) begin : g_node
        if (2*j + 1 < N_SRC) begin : g_add
          assign nxt[j*WIDTH +: WIDTH] = src[2*j*WIDTH +: WIDTH] + src[(2*j+1)*WIDTH +: WIDTH];
        end else begin : g_pass
          assign nxt[j*WIDTH +: WIDTH] = src[2*j*WIDTH +: WIDTH];
        end
      end

      always_ff @(posedge clk) begin
        if (en) dst <= nxt;
      end
    end
  endgenerate

  assign sum    = g_lvl[DEPTH-1].dst;
  assign sb_out = sb[DEPTH-1];

endmodule

// File: rtl/mac_tree_acc.sv
// Pipelined N-tap signed dot product with partial-sum leaf, group accumulator and scaled output.
module mac_tree_acc
  import mac_pkg::*;
#(
  parameter int unsigned N_TAPS            = 9,
  parameter int unsigned A_WIDTH           = 16,
  parameter int unsigned B_WIDTH           = 16,
  parameter int unsigned ACCUMULATOR_WIDTH = 32,
  parameter int unsigned OUTPUT_WIDTH      = 16,
  parameter int unsigned OUTPUT_SCALE      = 0
) (
  input logic            clk,
  input logic            srst_in,
  mac_tree_acc_if.slave  bus
);
  localparam int unsigned N_LEAVES = N_TAPS + 1;
  localparam int unsigned PROD_W   = A_WIDTH + B_WIDTH;
  localparam int unsigned ACC_W    = ACCUMULATOR_WIDTH;

  logic                      en;
  logic [N_LEAVES*ACC_W-1:0] leaf_d;
  logic [N_LEAVES*ACC_W-1:0] leaf_q;
  mac_sb_t                   sb_d;
  mac_sb_t                   sb_q;
  mac_sb_t                   tree_sb;
  logic [ACC_W-1:0]          tree_sum;
  logic [ACC_W-1:0]          acc;
  logic [ACC_W-1:0]          acc_next;
  logic [OUTPUT_WIDTH:0]     scaled;
  logic [OUTPUT_WIDTH-1:0]   out_q;
  logic                      out_valid_q;
  logic                      sat_q;

  function automatic logic [OUTPUT_WIDTH:0] scale_out(input logic [ACC_W-1:0] x);
    sat_res_t r;
    r = sat_scale({{(MAX_W-ACC_W){x[ACC_W-1]}}, x}, OUTPUT_SCALE, OUTPUT_WIDTH);
    return {r.sat, r.value[OUTPUT_WIDTH-1:0]};
  endfunction

  assign en              = !(out_valid_q && !bus.out_ready);
  assign bus.input_ready = en;
  assign bus.out         = out_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.sat_out     = sat_q;

  genvar i;
  generate
    for (i = 0; i < N_TAPS; i++) begin : g_mul
      logic signed [PROD_W-1:0] p;
      assign p = $signed(bus.a_in[i*A_WIDTH +: A_WIDTH]) * $signed(bus.b_in[i*B_WIDTH +: B_WIDTH]);
      if (PROD_W >= ACC_W) begin : g_trunc
        assign leaf_d[i*ACC_W +: ACC_W] = p[ACC_W-1:0];
      end else begin : g_sext
        assign leaf_d[i*ACC_W +: ACC_W] = {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
      end
    end
  endgenerate

  assign leaf_d[N_TAPS*ACC_W +: ACC_W] = bus.partial_sum_in;
  assign sb_d = '{valid: bus.input_valid, first: bus.first_in, last: bus.last_in};

  always_ff @(posedge clk) begin
    if (srst_in) begin
      sb_q <= '0;
    end else if (en) begin
      sb_q   <= sb_d;
      leaf_q <= leaf_d;
    end
  end

  mac_adder_tree #(
    .N_LEAVES(N_LEAVES),
    .WIDTH   (ACC_W)
  ) u_tree (
    .clk   (clk),
    .srst  (srst_in),
    .en    (en),
    .leaves(leaf_q),
    .sb_in (sb_q),
    .sum   (tree_sum),
    .sb_out(tree_sb)
  );

  always_comb begin
    acc_next = (tree_sb.first ? '0 : acc) + tree_sum;
    scaled   = scale_out(acc_next);
  end

  always_ff @(posedge clk) begin
    if (srst_in) begin
      acc         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else if (en) begin
      out_valid_q <= tree_sb.valid && tree_sb.last;
      if (tree_sb.valid) begin
        acc <= acc_next;
        if (tree_sb.last) begin
          out_q <= scaled[OUTPUT_WIDTH-1:0];
          sat_q <= scaled[OUTPUT_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_tree_acc.sv
// Directed self-checking bench for mac_tree_acc (scale 0 and scale 2 instances driven in lockstep).
module tb_mac_tree_acc;
  localparam int N  = 9;
  localparam int AW = 16;
  localparam int BW = 16;
  localparam int CW = 32;
  localparam int OW = 16;

  logic clk  = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  mac_tree_acc_if #(.N_TAPS(N), .A_WIDTH(AW), .B_WIDTH(BW), .ACCUMULATOR_WIDTH(CW), .OUTPUT_WIDTH(OW)) bus0 ();
  mac_tree_acc_if #(.N_TAPS(N), .A_WIDTH(AW), .B_WIDTH(BW), .ACCUMULATOR_WIDTH(CW), .OUTPUT_WIDTH(OW)) bus2 ();

  mac_tree_acc #(.N_TAPS(N), .A_WIDTH(AW), .B_WIDTH(BW), .ACCUMULATOR_WIDTH(CW),
                 .OUTPUT_WIDTH(OW), .OUTPUT_SCALE(0)) u_dut0 (.clk(clk), .srst_in(srst), .bus(bus0));
  mac_tree_acc #(.N_TAPS(N), .A_WIDTH(AW), .B_WIDTH(BW), .ACCUMULATOR_WIDTH(CW),
                 .OUTPUT_WIDTH(OW), .OUTPUT_SCALE(2)) u_dut2 (.clk(clk), .srst_in(srst), .bus(bus2));

  int checks   = 0;
  int failures = 0;
  int av [N];
  int bv [N];
  int ps;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic v, input logic f, input logic l);
    for (int i = 0; i < N; i++) begin
      bus0.a_in[i*AW +: AW] = av[i][AW-1:0];
      bus0.b_in[i*BW +: BW] = bv[i][BW-1:0];
      bus2.a_in[i*AW +: AW] = av[i][AW-1:0];
      bus2.b_in[i*BW +: BW] = bv[i][BW-1:0];
    end
    bus0.partial_sum_in = ps;
    bus2.partial_sum_in = ps;
    bus0.input_valid = v;  bus2.input_valid = v;
    bus0.first_in    = f;  bus2.first_in    = f;
    bus0.last_in     = l;  bus2.last_in     = l;
  endtask

  task automatic set_ready(input logic r);
    bus0.out_ready = r;
    bus2.out_ready = r;
  endtask

  task automatic basic_vec();  // sum = 2*(1+..+9) + 10 = 100
    for (int i = 0; i < N; i++) begin av[i] = i + 1; bv[i] = 2; end
    ps = 10;
  endtask

  task automatic uniform_vec(input int a, input int b, input int p);
    for (int i = 0; i < N; i++) begin av[i] = a; bv[i] = b; end
    ps = p;
  endtask

  task automatic single_vec(input int a0, input int b0, input int p);
    uniform_vec(0, 0, p);
    av[0] = a0;
    bv[0] = b0;
  endtask

  task automatic stream_vec(input int k);
    for (int i = 0; i < N; i++) begin av[i] = 3*k + i - 10; bv[i] = k - i; end
    ps = k * 100;
  endtask

  function automatic int model();
    int s;
    s = ps;
    for (int i = 0; i < N; i++) s += av[i] * bv[i];
    return s;
  endfunction

  task automatic test_reset();
    uniform_vec(0, 0, 0);
    apply(0, 0, 0);
    set_ready(1'b1);
    srst = 1'b1;
    tick(); tick();
    checks++; if (bus0.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", bus0.out_valid); end
    checks++; if (bus0.out !== 16'h0) begin failures++; $display("FAIL reset_out got %h want 0", bus0.out); end
    checks++; if (bus0.sat_out !== 1'b0) begin failures++; $display("FAIL reset_sat got %b want 0", bus0.sat_out); end
    checks++; if (bus0.input_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", bus0.input_ready); end
    srst = 1'b0;
  endtask

  task automatic test_basic_sum();
    basic_vec();
    apply(1, 1, 1);
    tick();
    apply(0, 0, 0);
    repeat (4) tick();
    checks++; if (bus0.out_valid !== 1'b0) begin failures++; $display("FAIL basic_early got %b want 0", bus0.out_valid); end
    tick();
    checks++; if (bus0.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got %b want 1", bus0.out_valid); end
    checks++; if ($signed(bus0.out) !== 100) begin failures++; $display("FAIL basic_out got %0d want 100", $signed(bus0.out)); end
    checks++; if (bus0.sat_out !== 1'b0) begin failures++; $display("FAIL basic_sat got %b want 0", bus0.sat_out); end
    checks++; if ($signed(bus2.out) !== 25) begin failures++; $display("FAIL basic_out_s2 got %0d want 25", $signed(bus2.out)); end
    tick();
    checks++; if (bus0.out_valid !== 1'b0) begin failures++; $display("FAIL basic_one_cycle got %b want 0", bus0.out_valid); end
  endtask

  task automatic test_back_to_back();
    int expv [20];
    for (int k = 0; k < 20; k++) begin stream_vec(k); expv[k] = model(); end
    for (int c = 0; c < 25; c++) begin
      if (c < 20) begin stream_vec(c); apply(1, 1, 1); end
      else apply(0, 0, 0);
      tick();
      checks++; if (bus0.input_ready !== 1'b1) begin failures++; $display("FAIL stream_ready c=%0d got %b want 1", c, bus0.input_ready); end
      if (c >= 5) begin
        checks++; if (bus0.out_valid !== 1'b1 || $signed(bus0.out) !== expv[c-5])
          begin failures++; $display("FAIL stream_out beat=%0d got v=%b %0d want v=1 %0d", c-5, bus0.out_valid, $signed(bus0.out), expv[c-5]); end
      end else begin
        checks++; if (bus0.out_valid !== 1'b0) begin failures++; $display("FAIL stream_idle c=%0d got %b want 0", c, bus0.out_valid); end
      end
    end
    apply(0, 0, 0);
    tick();
    checks++; if (bus0.out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got %b want 0", bus0.out_valid); end
  endtask

  task automatic test_backpressure();
    for (int m = 1; m <= 3; m++) begin uniform_vec(1, m, 0); apply(1, 1, 1); tick(); end
    apply(0, 0, 0);
    tick(); tick(); tick();
    checks++; if (bus0.out_valid !== 1'b1 || $signed(bus0.out) !== 9) begin failures++; $display("FAIL bp_first got v=%b %0d want v=1 9", bus0.out_valid, $signed(bus0.out)); end
    set_ready(1'b0);
    uniform_vec(1, 4, 0);
    apply(1, 1, 1);
    #1;
    checks++; if (bus0.input_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got %b want 0", bus0.input_ready); end
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++; if (bus0.out_valid !== 1'b1 || $signed(bus0.out) !== 9 || bus0.sat_out !== 1'b0 || bus0.input_ready !== 1'b0)
        begin failures++; $display("FAIL bp_hold s=%0d got v=%b out=%0d sat=%b rdy=%b want v=1 out=9 sat=0 rdy=0", s, bus0.out_valid, $signed(bus0.out), bus0.sat_out, bus0.input_ready); end
    end
    set_ready(1'b1);
    tick();
    apply(0, 0, 0);
    checks++; if (bus0.out_valid !== 1'b1 || $signed(bus0.out) !== 18) begin failures++; $display("FAIL bp_second got v=%b %0d want v=1 18", bus0.out_valid, $signed(bus0.out)); end
    tick();
    checks++; if (bus0.out_valid !== 1'b1 || $signed(bus0.out) !== 27) begin failures++; $display("FAIL bp_third got v=%b %0d want v=1 27", bus0.out_valid, $signed(bus0.out)); end
    tick();
    checks++; if (bus0.out_valid !== 1'b0) begin failures++; $display("FAIL bp_gap got %b want 0", bus0.out_valid); end
    tick(); tick(); tick();
    checks++; if (bus0.out_valid !== 1'b1 || $signed(bus0.out) !== 36) begin failures++; $display("FAIL bp_held_beat got v=%b %0d want v=1 36", bus0.out_valid, $signed(bus0.out)); end
    tick();
    checks++; if (bus0.out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup got %b want 0", bus0.out_valid); end
  endtask

  task automatic test_accumulate();
    basic_vec(); apply(1, 1, 0); tick();
    apply(1, 0, 0); tick();
    apply(1, 0, 1); tick();
    single_vec(6, 1, 0); apply(1, 0, 1); tick();
    apply(0, 0, 0);
    tick(); tick();
    checks++; if (bus0.out_valid !== 1'b0) begin failures++; $display("FAIL acc_beat1 got %b want 0", bus0.out_valid); end
    tick();
    checks++; if (bus0.out_valid !== 1'b0) begin failures++; $display("FAIL acc_beat2 got %b want 0", bus0.out_valid); end
    tick();
    checks++; if (bus0.out_valid !== 1'b1 || $signed(bus0.out) !== 300) begin failures++; $display("FAIL acc_group got v=%b %0d want v=1 300", bus0.out_valid, $signed(bus0.out)); end
    checks++; if ($signed(bus2.out) !== 75) begin failures++; $display("FAIL acc_group_s2 got %0d want 75", $signed(bus2.out)); end
    tick();
    checks++; if (bus0.out_valid !== 1'b1 || $signed(bus0.out) !== 306) begin failures++; $display("FAIL acc_last_no_first got v=%b %0d want v=1 306", bus0.out_valid, $signed(bus0.out)); end
    checks++; if ($signed(bus2.out) !== 77) begin failures++; $display("FAIL acc_last_no_first_s2 got %0d want 77", $signed(bus2.out)); end
    basic_vec(); apply(1, 1, 0); tick();
    single_vec(6, 1, 0); apply(1, 1, 1); tick();
    apply(0, 0, 0);
    repeat (4) tick();
    checks++; if (bus0.out_valid !== 1'b0) begin failures++; $display("FAIL acc_discard_open got %b want 0", bus0.out_valid); end
    tick();
    checks++; if (bus0.out_valid !== 1'b1 || $signed(bus0.out) !== 6) begin failures++; $display("FAIL acc_restart got v=%b %0d want v=1 6", bus0.out_valid, $signed(bus0.out)); end
  endtask

  task automatic test_round_saturate();
    int a0 [4] = '{6, 0, 200, -200};
    int p0 [4] = '{0, -6, 0, 0};
    int b0 [4] = '{1, 0, 200, 200};
    int e0 [4] = '{6, -6, 32767, -32768};
    int s0 [4] = '{0, 0, 1, 1};
    int e2 [4] = '{2, -1, 10000, -10000};
    for (int c = 0; c < 9; c++) begin
      if (c < 4) begin single_vec(a0[c], b0[c], p0[c]); apply(1, 1, 1); end
      else apply(0, 0, 0);
      tick();
      if (c >= 5) begin
        checks++; if (bus0.out_valid !== 1'b1 || $signed(bus0.out) !== e0[c-5] || bus0.sat_out !== s0[c-5][0])
          begin failures++; $display("FAIL sat_s0 case=%0d got v=%b %0d sat=%b want v=1 %0d sat=%0d", c-5, bus0.out_valid, $signed(bus0.out), bus0.sat_out, e0[c-5], s0[c-5]); end
        checks++; if ($signed(bus2.out) !== e2[c-5] || bus2.sat_out !== 1'b0)
          begin failures++; $display("FAIL round_s2 case=%0d got %0d sat=%b want %0d sat=0", c-5, $signed(bus2.out), bus2.sat_out, e2[c-5]); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    basic_vec(); apply(1, 1, 0); tick();
    repeat (3) begin apply(1, 0, 0); tick(); end
    apply(1, 0, 1); tick();
    apply(0, 0, 0);
    tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    checks++; if (bus0.out_valid !== 1'b0 || bus0.out !== 16'h0 || bus0.sat_out !== 1'b0 || bus0.input_ready !== 1'b1)
      begin failures++; $display("FAIL midrst_state got v=%b out=%h sat=%b rdy=%b want 0 0000 0 1", bus0.out_valid, bus0.out, bus0.sat_out, bus0.input_ready); end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (bus0.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_flush c=%0d got %b want 0", c, bus0.out_valid); end
    end
    single_vec(6, 1, 0); apply(1, 0, 1); tick();
    apply(0, 0, 0);
    repeat (5) tick();
    checks++; if (bus0.out_valid !== 1'b1 || $signed(bus0.out) !== 6) begin failures++; $display("FAIL midrst_residue got v=%b %0d want v=1 6", bus0.out_valid, $signed(bus0.out)); end
    checks++; if ($signed(bus2.out) !== 2) begin failures++; $display("FAIL midrst_residue_s2 got %0d want 2", $signed(bus2.out)); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_sum();
    test_back_to_back();
    test_backpressure();
    test_accumulate();
    test_round_saturate();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
